// File: rtl/multiplier_sa.sv
// Purpose: sequential shift-add multiplier, one operand pair per operation, unsigned or two's-complement.
// Latency: start accepted at edge N -> done pulses in the cycle after edge N+BITS+1; one op per BITS+2 cycles.
// Backpressure: none; start is only sampled in IDLE and is ignored while busy.
module multiplier_sa #(
    parameter int BITS   = 16,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BITS-1:0]   multiplicand,
    input  logic [BITS-1:0]   multiplier,
    output logic              done,
    output logic [2*BITS-1:0] product,
    output logic              busy
);

    localparam int PW = 2 * BITS;
    localparam int CW = $clog2(BITS + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q,   state_d;
    logic [BITS-1:0] mcand_q,   mcand_d;
    logic [BITS-1:0] mplr_q,    mplr_d;
    // Upper accumulator half plus one carry bit; the lower half shares the multiplier register.
    logic [BITS:0]   acc_q,     acc_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic            neg_q,     neg_d;
    logic            done_q,    done_d;
    logic [PW-1:0]   product_q, product_d;

    logic [BITS-1:0] a_mag;
    logic [BITS-1:0] b_mag;
    logic            a_neg;
    logic            b_neg;
    logic [BITS:0]   addend;
    logic [BITS:0]   sum;
    logic [PW-1:0]   prod_mag;

    // Operand magnitudes; -2^(BITS-1) maps onto itself, which is its correct unsigned magnitude.
    always_comb begin
        a_neg = (SIGNED != 0) && multiplicand[BITS-1];
        b_neg = (SIGNED != 0) && multiplier[BITS-1];
        a_mag = a_neg ? -multiplicand : multiplicand;
        b_mag = b_neg ? -multiplier   : multiplier;
    end

    // One shift-add step: conditional add into the upper half, then the whole chain shifts right.
    always_comb begin
        addend   = mplr_q[0] ? {1'b0, mcand_q} : '0;
        sum      = acc_q + addend;
        prod_mag = {acc_q[BITS-1:0], mplr_q};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_MULT;
                    mcand_d = a_mag;
                    mplr_d  = b_mag;
                    neg_d   = a_neg ^ b_neg;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_MULT: begin
                acc_d  = {1'b0, sum[BITS:1]};
                mplr_d = {sum[0], mplr_q[BITS-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                product_d = neg_q ? -prod_mag : prod_mag;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset wins over a simultaneous start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    // Outputs come straight from flops so they cannot glitch with start.
    always_comb begin
        done    = done_q;
        product = product_q;
        busy    = (state_q != S_IDLE);
    end

endmodule

// File: doc/multiplier_sa.md
MULTIPLIER_SA -- requirements
Module: multiplier_sa

Interface
REQ-001 Parameter BITS, default 16: operand width; product width is 2*BITS; legal range 2..32.
REQ-002 Parameter SIGNED, default 0: 0 = unsigned operands and product; 1 = two's-complement operands and product.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 multiplicand  input  BITS  operand A; captured on the accepting edge.
REQ-007 multiplier  input  BITS  operand B; captured on the accepting edge.
REQ-008 done  output  1  one-cycle pulse; product valid.
REQ-009 product  output  2*BITS  result; held from done until the next accepted start.
REQ-010 busy  output  1  high in MULT and DONE states.

Function
REQ-011 States SHALL be IDLE, MULT and DONE, held in a registered FSM.
REQ-012 IDLE with start=1 -> MULT: capture A and B (magnitudes when SIGNED=1), record result sign = sign(A) XOR sign(B), clear accumulator, set iteration counter to 0.
REQ-013 In MULT, each cycle: if the current multiplier LSB is 1, add the multiplicand to the upper BITS+1 accumulator bits; shift the {carry, accumulator, multiplier} chain right by 1; increment the counter.
REQ-014 MULT -> DONE after exactly BITS iterations; no early termination on zero operands.
REQ-015 In DONE: product <= accumulator, two's-complement negated when SIGNED=1 and sign=1; done=1 for exactly this cycle; next state IDLE.
REQ-016 Latency: with start sampled at edge N, done SHALL be high in the cycle following edge N+BITS+1; throughput is one operation per BITS+2 cycles.
REQ-017 start while busy=1 SHALL be ignored; operands and progress of the current operation are unaffected.
REQ-018 start held high in IDLE immediately after DONE SHALL be accepted on that IDLE edge (back-to-back operations allowed).
REQ-019 The accumulator SHALL be wide enough that no overflow occurs: unsigned max (2^BITS-1)^2 and signed -2^(BITS-1) * -2^(BITS-1) = 2^(2*BITS-2) are both exact.
REQ-020 Operand input changes after the accepting edge SHALL NOT affect the result.
REQ-021 product SHALL change only in DONE or on reset; done and product never glitch with start.

Reset
REQ-022 reset=1 at a rising edge SHALL force IDLE, done=0, busy=0, product=0, counter=0, accumulator=0, regardless of state.
REQ-023 reset asserted mid-MULT SHALL abort the operation with no done pulse; the first start after reset deasserts is accepted normally.
REQ-024 reset and start high on the same edge: reset wins and start is discarded.

Verification
REQ-025 BITS=16, SIGNED=0: A=11, B=3, start for 1 cycle -> done pulses 17 cycles after the start edge, product=33, busy high for 17 cycles.
REQ-026 SIGNED=0: A=0xFFFF, B=0xFFFF -> product=0xFFFE0001; A=0, B=0x1234 -> product=0 with the same 17-cycle latency.
REQ-027 SIGNED=1: A=-3 (0xFFFD), B=5 -> product=0xFFFFFFF1; A=0x8000, B=0x8000 -> product=0x40000000.
REQ-028 Start A=7, B=6; pulse start with A=2, B=2 at cycle 5 -> single done, product=42, second start ignored.
REQ-029 Start A=100, B=100; assert reset at cycle 8 -> no done, product=0, busy=0; a new start with A=9, B=9 -> product=81.
REQ-030 100 random operand pairs per SIGNED setting, self-checking against the behavioural product on every done; any mismatch stops simulation.
